jts16_fd1094_seq: RTL and testbench
===================================

Name: jts16_fd1094_seq

Overview:
- Parametrised FD1094 key-state sequencer, next generation of the S16 FD1094 state controller.
- Sits between the 68000 bus monitor and the FD1094 opcode decryptor. It watches decrypted supervisor opcode fetches for the state-change command sequence "cmpi.l #imm, ... ; $FFFF" and produces the key-state byte fed to the decryptor.
- New over the previous generation:
  - interrupt nesting counter of configurable depth instead of a single irq flag;
  - configurable command opcode match and terminator word;
  - explicit sequencer FSM;
  - state-change strobe for downstream decode-cache invalidation;
  - sticky overflow flag.

Parameters:
- DEPTH, 2, maximum interrupt nesting level tracked (1..15).
- OPMASK, 16'hFFC0, mask applied to the fetched word for command detection.
- OPVAL, 16'h0C80, value that (dec & OPMASK) must equal to start a command (cmpi.l #imm).
- TERM, 16'hFFFF, terminator word that commits a command.
- RTEOP, 16'h4E73, opcode that pops one nesting level.

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- inta_n  in  1  68000 interrupt acknowledge, active low.
- op_n  in  1  low = current bus cycle is an opcode/immediate fetch.
- dtackn  in  1  68000 DTACK, active low.
- sup_prog  in  1  high = supervisor program space.
- dec  in  16  decrypted word on the bus.
- gkey0  in  8  global key byte used while in interrupt mode.
- st  out  8  key state to decryptor; equals gkey0 when level!=0, else state.
- irqmode  out  1  level!=0.
- level  out  4  current nesting level, 0..DEPTH.
- ovf  out  1  sticky: a push was attempted at level==DEPTH.
- stchg  out  1  one-cycle pulse when st source or state value changes.

Behaviour:
- Reset (rst_n low, asynchronous): state=0, level=0, ovf=0, stchg=0, FSM=IDLE, stcode=0, dtack_l=1, inta_l=1, miss=0.
- Cycle accept, acc: dtack_l & ~dtackn, where dtack_l is dtackn registered. One pulse per bus cycle.
- Fetch accept, fa: acc & ~op_n & sup_prog. Data accept, da: acc & op_n.
- All updates are registered; st, irqmode and level reflect an update on the clock edge after the accepting edge.
- FSM states: IDLE, IMM_HI, IMM_LO.
  - Any state, fa with (dec&OPMASK)==OPVAL: go to IMM_HI, miss=0. This restarts an in-progress sequence.
  - IMM_HI, fa (non-matching): if dec[15:10]==0, latch stcode=dec and go to IMM_LO; else go to IDLE.
  - IMM_LO, fa: if dec==TERM, execute stcode[9:8]. Go to IDLE regardless.
  - IMM_HI/IMM_LO, da: first da sets miss=1; a second consecutive da aborts to IDLE. Any fa clears miss.
  - acc with ~op_n & ~sup_prog (user fetch) in IMM_HI/IMM_LO: go to IDLE.
- Commands (stcode[9:8]):
  - 0: state = stcode[7:0].
  - 1: state = 0, level = 0, ovf = 0.
  - 2: push.
  - 3: pop.
- Interrupt acknowledge edge: inta_l & ~inta_n (inta_l is inta_n registered) = push.
- fa with dec==RTEOP in any FSM state = pop.
- Push: if level<DEPTH, level+1; else level unchanged and ovf=1.
- Pop: if level>0, level-1; at 0, no-op.
- Same-cycle push and pop: level unchanged, no ovf.
- Command 1 coincident with a push: reset wins, level = 0.
- stchg asserts for one cycle when state changes value, or when irqmode toggles. Loading an identical state gives no pulse.
- gkey0 changing while irqmode=1 does not pulse stchg.
- Reset mid-sequence: FSM to IDLE immediately. A TERM word fetched afterwards has no effect.

Decomposition:
- Shared package jts16_fd1094_pkg:
  - FSM state enum (IDLE/IMM_HI/IMM_LO);
  - command codes CMD_LOAD=0, CMD_RST=1, CMD_PUSH=2, CMD_POP=3;
  - default OPMASK/OPVAL/TERM/RTEOP constants.
- One natural sub-module, jts16_fd1094_nest: saturating up/down level counter with push/pop/clear inputs and level/ovf outputs.

Test Plan:
- Fetch $0C80, $0012, $FFFF, all supervisor, one DTACK each -> state=$12, st=$12, stchg one pulse, level=0.
- Fetch $0C80, $0112, $FFFF after state=$12 -> state=0, level=0, ovf=0.
- Sequence $0C80, $0012, one data cycle, $FFFF -> state=$12 applied. Same with two data cycles before $FFFF -> state unchanged, FSM IDLE.
- Three inta_n falling edges with DEPTH=2 -> level 1, 2, 2; ovf=1; st=gkey0=$A5. Then fetch $4E73 twice -> level 1, then 0; st=state.
- inta_n falling edge in the same clock as a fa of $4E73 at level=1 -> level stays 1, ovf unchanged.
- Fetch $0C80, $FC12 -> abort to IDLE. Then $FFFF -> no state change.
- Assert rst_n low between $0012 and $FFFF -> all outputs 0, and the later $FFFF is ignored.

Source files
------------

// File: rtl/jts16_fd1094_pkg.sv
// rtl/jts16_fd1094_pkg.sv - shared types and constants for the FD1094 key-state sequencer
package jts16_fd1094_pkg;

    // Command sequencer states: waiting, expecting immediate high word, expecting terminator
    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_IMM_HI = 2'd1,
        SEQ_IMM_LO = 2'd2
    } seq_state_t;

    // Command codes carried in bits [9:8] of the immediate word
    localparam logic [1:0] CMD_LOAD = 2'd0;
    localparam logic [1:0] CMD_RST  = 2'd1;
    localparam logic [1:0] CMD_PUSH = 2'd2;
    localparam logic [1:0] CMD_POP  = 2'd3;

    // Default command detection and terminator words
    localparam logic [15:0] DEF_OPMASK = 16'hFFC0;
    localparam logic [15:0] DEF_OPVAL  = 16'h0C80;
    localparam logic [15:0] DEF_TERM   = 16'hFFFF;
    localparam logic [15:0] DEF_RTEOP  = 16'h4E73;

endpackage

// File: rtl/jts16_fd1094_nest.sv
// rtl/jts16_fd1094_nest.sv - saturating interrupt nesting level counter with sticky overflow
module jts16_fd1094_nest #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       clr,
    output logic [3:0] level,
    output logic [3:0] level_nxt,
    output logic       ovf
);

    localparam logic [3:0] MAXLVL = 4'(DEPTH);

    logic ovf_nxt;

    // Next level: clear dominates, simultaneous push and pop cancel out
    always_comb begin
        level_nxt = level;
        ovf_nxt   = ovf;
        if (clr) begin
            level_nxt = 4'd0;
            ovf_nxt   = 1'b0;
        end else if (push && !pop) begin
            if (level < MAXLVL)
                level_nxt = level + 4'd1;
            else
                ovf_nxt = 1'b1;
        end else if (pop && !push) begin
            if (level != 4'd0)
                level_nxt = level - 4'd1;
        end
    end

    // Level and overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 4'd0;
            ovf   <= 1'b0;
        end else begin
            level <= level_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: rtl/jts16_fd1094_seq.sv
// rtl/jts16_fd1094_seq.sv - FD1094 key-state sequencer watching supervisor opcode fetches
module jts16_fd1094_seq
    import jts16_fd1094_pkg::*;
#(
    parameter int          DEPTH  = 2,
    parameter logic [15:0] OPMASK = DEF_OPMASK,
    parameter logic [15:0] OPVAL  = DEF_OPVAL,
    parameter logic [15:0] TERM   = DEF_TERM,
    parameter logic [15:0] RTEOP  = DEF_RTEOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inta_n,
    input  logic        op_n,
    input  logic        dtackn,
    input  logic        sup_prog,
    input  logic [15:0] dec,
    input  logic [7:0]  gkey0,
    output logic [7:0]  st,
    output logic        irqmode,
    output logic [3:0]  level,
    output logic        ovf,
    output logic        stchg
);

    logic       dtack_l, inta_l;
    logic       acc, fa, da, uf, irq_edge;
    seq_state_t fsm, fsm_nxt;
    logic       miss, miss_nxt;
    logic [9:0] stcode, stcode_nxt;
    logic [7:0] state, state_nxt;
    logic       exec, clr, cmd_push, cmd_pop, push, pop;
    logic [3:0] level_nxt;

    // One accept per bus cycle, on the DTACK falling edge
    assign acc      = dtack_l & ~dtackn;
    assign fa       = acc & ~op_n & sup_prog;
    assign da       = acc & op_n;
    assign uf       = acc & ~op_n & ~sup_prog;
    assign irq_edge = inta_l & ~inta_n;

    // Sequencer next state: a command opcode always restarts, data cycles tolerate one miss
    always_comb begin
        fsm_nxt    = fsm;
        miss_nxt   = miss;
        stcode_nxt = stcode;
        exec       = 1'b0;
        if (fa && ((dec & OPMASK) == OPVAL)) begin
            fsm_nxt  = SEQ_IMM_HI;
            miss_nxt = 1'b0;
        end else if (fa) begin
            miss_nxt = 1'b0;
            case (fsm)
                SEQ_IMM_HI: begin
                    if (dec[15:10] == 6'd0) begin
                        stcode_nxt = dec[9:0];
                        fsm_nxt    = SEQ_IMM_LO;
                    end else begin
                        fsm_nxt = SEQ_IDLE;
                    end
                end
                SEQ_IMM_LO: begin
                    exec    = (dec == TERM);
                    fsm_nxt = SEQ_IDLE;
                end
                default: fsm_nxt = SEQ_IDLE;
            endcase
        end else if (da && fsm != SEQ_IDLE) begin
            if (miss) begin
                fsm_nxt  = SEQ_IDLE;
                miss_nxt = 1'b0;
            end else begin
                miss_nxt = 1'b1;
            end
        end else if (uf && fsm != SEQ_IDLE) begin
            fsm_nxt  = SEQ_IDLE;
            miss_nxt = 1'b0;
        end
    end

    // Committed command decode
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        cmd_push  = 1'b0;
        cmd_pop   = 1'b0;
        if (exec) begin
            case (stcode[9:8])
                CMD_LOAD: state_nxt = stcode[7:0];
                CMD_RST: begin
                    state_nxt = 8'd0;
                    clr       = 1'b1;
                end
                CMD_PUSH: cmd_push = 1'b1;
                default:  cmd_pop  = 1'b1;
            endcase
        end
    end

    assign push = irq_edge | cmd_push;
    assign pop  = (fa && dec == RTEOP) | cmd_pop;

    jts16_fd1094_nest #(.DEPTH(DEPTH)) u_nest (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .clr       (clr),
        .level     (level),
        .level_nxt (level_nxt),
        .ovf       (ovf)
    );

    // Sequencer, state byte and edge-detect registers; stchg lines up with the new st
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dtack_l <= 1'b1;
            inta_l  <= 1'b1;
            fsm     <= SEQ_IDLE;
            miss    <= 1'b0;
            stcode  <= 10'd0;
            state   <= 8'd0;
            stchg   <= 1'b0;
        end else begin
            dtack_l <= dtackn;
            inta_l  <= inta_n;
            fsm     <= fsm_nxt;
            miss    <= miss_nxt;
            stcode  <= stcode_nxt;
            state   <= state_nxt;
            stchg   <= (state_nxt != state) |
                       ((level_nxt != 4'd0) != (level != 4'd0));
        end
    end

    assign irqmode = (level != 4'd0);
    assign st      = irqmode ? gkey0 : state;

endmodule

// File: tb/tb_jts16_fd1094_seq.sv
// tb/tb_jts16_fd1094_seq.sv - directed self-checking bench for jts16_fd1094_seq
module tb_jts16_fd1094_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inta_n = 1'b1;
    logic        op_n = 1'b1;
    logic        dtackn = 1'b1;
    logic        sup_prog = 1'b1;
    logic [15:0] dec = 16'h0000;
    logic [7:0]  gkey0 = 8'hA5;
    logic [7:0]  st;
    logic        irqmode;
    logic [3:0]  level;
    logic        ovf;
    logic        stchg;

    int tests = 0;
    int fails = 0;
    int stchg_cnt = 0;
    int cnt0;

    jts16_fd1094_seq #(.DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inta_n   (inta_n),
        .op_n     (op_n),
        .dtackn   (dtackn),
        .sup_prog (sup_prog),
        .dec      (dec),
        .gkey0    (gkey0),
        .st       (st),
        .irqmode  (irqmode),
        .level    (level),
        .ovf      (ovf),
        .stchg    (stchg)
    );

    always #5 clk = ~clk;

    // Count stchg pulses, sampled away from the rising edge
    always @(negedge clk) if (stchg) stchg_cnt <= stchg_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic opn, input logic sup, input logic [15:0] d);
        @(negedge clk);
        op_n = opn; sup_prog = sup; dec = d; dtackn = 1'b0;
        @(negedge clk);
        dtackn = 1'b1;
        @(negedge clk);
    endtask

    task automatic fetch(input logic [15:0] d);
        bus(1'b0, 1'b1, d);
    endtask

    task automatic irq();
        @(negedge clk);
        inta_n = 1'b0;
        @(negedge clk);
        inta_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // reset state
        #1;
        check("rst_st", 16'(st), 16'h00);
        check("rst_level", 16'(level), 16'h0);
        check("rst_ovf", 16'(ovf), 16'h0);
        check("rst_stchg", 16'(stchg), 16'h0);
        check("rst_irqmode", 16'(irqmode), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // load state $12
        cnt0 = stchg_cnt;
        fetch(16'h0C80); fetch(16'h0012); fetch(16'hFFFF);
        repeat (2) @(negedge clk);
        check("load_st", 16'(st), 16'h12);
        check("load_level", 16'(level), 16'h0);
        check("load_stchg_pulses", 16'(stchg_cnt - cnt0), 16'd1);

        // identical reload gives no pulse
        cnt0 = stchg_cnt;
        fetch(16'h0C80); fetch(16'h0012); fetch(16'hFFFF);
        repeat (2) @(negedge clk);
        check("reload_same_pulses", 16'(stchg_cnt - cnt0), 16'd0);

        // command 1 resets state
        cnt0 = stchg_cnt;
        fetch(16'h0C80); fetch(16'h0112); fetch(16'hFFFF);
        check("cmd1_st", 16'(st), 16'h00);
        check("cmd1_level", 16'(level), 16'h0);
        check("cmd1_ovf", 16'(ovf), 16'h0);
        @(negedge clk);
        check("cmd1_pulses", 16'(stchg_cnt - cnt0), 16'd1);

        // one data cycle tolerated
        fetch(16'h0C80); fetch(16'h0012); bus(1'b1, 1'b1, 16'h1234); fetch(16'hFFFF);
        check("one_miss_st", 16'(st), 16'h12);

        // two data cycles abort, later TERM ignored
        fetch(16'h0C80); fetch(16'h0034); bus(1'b1, 1'b1, 16'h1234); bus(1'b1, 1'b1, 16'h5678);
        fetch(16'hFFFF);
        check("two_miss_st", 16'(st), 16'h12);
        fetch(16'hFFFF);
        check("two_miss_idle_st", 16'(st), 16'h12);

        // user fetch aborts
        fetch(16'h0C80); fetch(16'h0034); bus(1'b0, 1'b0, 16'h0000); fetch(16'hFFFF);
        check("user_abort_st", 16'(st), 16'h12);

        // interrupt nesting up to saturation
        cnt0 = stchg_cnt;
        irq();
        check("irq1_level", 16'(level), 16'h1);
        check("irq1_st", 16'(st), 16'hA5);
        check("irq1_irqmode", 16'(irqmode), 16'h1);
        check("irq1_pulses", 16'(stchg_cnt - cnt0), 16'd1);
        cnt0 = stchg_cnt;
        irq();
        check("irq2_level", 16'(level), 16'h2);
        check("irq2_ovf", 16'(ovf), 16'h0);
        irq();
        check("irq3_level", 16'(level), 16'h2);
        check("irq3_ovf", 16'(ovf), 16'h1);
        @(negedge clk);
        check("irq23_pulses", 16'(stchg_cnt - cnt0), 16'd0);

        // global key change in interrupt mode
        cnt0 = stchg_cnt;
        @(negedge clk); gkey0 = 8'h5A;
        repeat (3) @(negedge clk);
        check("gkey_st", 16'(st), 16'h5A);
        check("gkey_pulses", 16'(stchg_cnt - cnt0), 16'd0);
        gkey0 = 8'hA5;

        // RTE pops back out
        fetch(16'h4E73);
        check("rte1_level", 16'(level), 16'h1);
        cnt0 = stchg_cnt;
        fetch(16'h4E73);
        check("rte2_level", 16'(level), 16'h0);
        check("rte2_st", 16'(st), 16'h12);
        @(negedge clk);
        check("rte2_pulses", 16'(stchg_cnt - cnt0), 16'd1);
        fetch(16'h4E73);
        check("rte_at0_level", 16'(level), 16'h0);

        // push and pop in the same cycle
        irq();
        @(negedge clk);
        inta_n = 1'b0; op_n = 1'b0; sup_prog = 1'b1; dec = 16'h4E73; dtackn = 1'b0;
        @(negedge clk);
        inta_n = 1'b1; dtackn = 1'b1;
        @(negedge clk);
        check("pushpop_level", 16'(level), 16'h1);
        check("pushpop_ovf", 16'(ovf), 16'h1);

        // command 1 clears level and overflow
        fetch(16'h0C80); fetch(16'h0112); fetch(16'hFFFF);
        check("clr_level", 16'(level), 16'h0);
        check("clr_ovf", 16'(ovf), 16'h0);
        check("clr_st", 16'(st), 16'h00);

        // command push and pop
        fetch(16'h0C80); fetch(16'h0200); fetch(16'hFFFF);
        check("cmdpush_level", 16'(level), 16'h1);
        check("cmdpush_st", 16'(st), 16'hA5);
        fetch(16'h0C80); fetch(16'h0300); fetch(16'hFFFF);
        check("cmdpop_level", 16'(level), 16'h0);

        // bad immediate aborts
        fetch(16'h0C80); fetch(16'h0012); fetch(16'hFFFF);
        check("reload12_st", 16'(st), 16'h12);
        fetch(16'h0C80); fetch(16'hFC12); fetch(16'h0055); fetch(16'hFFFF);
        check("badimm_st", 16'(st), 16'h12);

        // restart of an in-progress sequence
        fetch(16'h0C80); fetch(16'h0C80); fetch(16'h0077); fetch(16'hFFFF);
        check("restart_st", 16'(st), 16'h77);

        // reset mid-sequence
        fetch(16'h0C80); fetch(16'h0034);
        irq();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_st", 16'(st), 16'h00);
        check("midrst_level", 16'(level), 16'h0);
        check("midrst_irqmode", 16'(irqmode), 16'h0);
        check("midrst_stchg", 16'(stchg), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(16'hFFFF);
        @(negedge clk);
        check("postrst_st", 16'(st), 16'h00);
        check("postrst_level", 16'(level), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
